// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared types and helpers for the FIFO stream reader
package fifo_stream_reader_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Skid buffer fill level; values double as the occupancy count.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_occ_e;

  // A new read may issue only if every word already owed to the skid
  // (held + in flight - leaving this cycle) leaves room for one more.
  function automatic logic skid_has_room(input logic [1:0] occ,
                                         input logic       inflight,
                                         input logic       pop);
    logic [2:0] committed;
    logic [2:0] limit;
    committed = {1'b0, occ} + {2'b00, inflight};
    limit     = 3'd2 + {2'b00, pop};
    return committed < limit;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// rtl/fifo_stream_reader_skid_buf2.sv - 2-entry in-order register buffer with push/pop/clear
module skid_buf2
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  skid_occ_e             occ_q;

  assign valid     = (occ_q != SKID_EMPTY);
  assign data      = head_q;
  assign occupancy = occ_q;

  // Head/tail shift register; head is only rewritten when it is popped or empty,
  // so a stalled head word stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= SKID_EMPTY;
    end else if (clear) begin
      occ_q <= SKID_EMPTY;
    end else begin
      case ({push, pop})
        2'b10: begin
          case (occ_q)
            SKID_EMPTY: begin
              head_q <= push_data;
              occ_q  <= SKID_ONE;
            end
            SKID_ONE: begin
              tail_q <= push_data;
              occ_q  <= SKID_FULL;
            end
            default: ; // full: upstream issue rule never pushes here
          endcase
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= (occ_q == SKID_FULL) ? SKID_ONE : SKID_EMPTY;
        end
        2'b11: begin
          if (occ_q == SKID_FULL) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a 1-cycle-latency FIFO into a valid/ready stream
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  fifo_flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic inflight_q;
  logic pop;
  logic push;

  assign pop = m_valid && m_ready;

  // The word read last cycle lands now; a flush in this cycle discards it.
  assign push = inflight_q && !flush_req;

  // Reset gates both strobes so the FIFO is never touched while in reset.
  assign fifo_read  = !rst && enable && !fifo_empty && !flush_req &&
                      skid_has_room(occupancy, inflight_q, pop);
  assign fifo_flush = !rst && flush_req;

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_req),
    .push      (push),
    .push_data (fifo_data),
    .pop       (pop),
    .valid     (m_valid),
    .data      (m_data),
    .occupancy (occupancy)
  );

  // Marks the cycle in which the FIFO's read data is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_read;
    end
  end

  // Counts completed beats, including one that completes alongside a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_out <= '0;
    end else if (pop) begin
      words_out <= words_out + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench with FIFO model and stream scoreboard
module tb_fifo_stream_reader;

  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          flush_req;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_read;
  logic          fifo_flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] words_out;

  logic          wr_en;
  logic [DW-1:0] wr_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush_req  (flush_req),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .fifo_flush (fifo_flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occupancy  (occupancy),
    .words_out  (words_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model (depth 4, 1-cycle read latency) and the scoreboard of words owed downstream.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            fifo_cnt   = 0;
  logic          inflight_m = 1'b0;
  logic [CW-1:0] words_m    = '0;
  logic          mon_on     = 1'b0;

  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clk) begin
    if (fifo_flush) begin
      fq.delete();
    end else if (fifo_read && fq.size() > 0) begin
      fifo_data <= fq[0];
      exp_q.push_back(fq[0]);
      void'(fq.pop_front());
    end
    if (!fifo_flush && wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
    if (rst || flush_req) exp_q.delete();
    if (rst) words_m = '0;
    inflight_m = fifo_read;
    fifo_cnt <= fq.size();
  end

  // Stream monitor: ordering, occupancy, counter, guard and stability checks every cycle.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      int held;
      held = exp_q.size() - int'(inflight_m);
      check_eq("rd_guard", 32'(fifo_read && (fifo_empty || flush_req)), 32'd0);
      check_eq("occupancy", 32'(occupancy), 32'(held));
      check_eq("m_valid", 32'(m_valid), 32'(held != 0));
      check_eq("words_out", 32'(words_out), 32'(words_m));
      if (prev_stall) check_eq("stable", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) begin
          check_eq("beat_data", 32'(m_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end else begin
          check_eq("beat_unexpected", 32'd1, 32'd0);
        end
        words_m = words_m + 16'd1;
      end
      prev_stall = m_valid && !m_ready && !flush_req && !rst;
      prev_data  = m_data;
    end
  end

  // Directed run: writes wr_list one per cycle, records per-cycle observations.
  logic [DW-1:0] wr_list[$];
  bit            rd_h [32];
  bit            vld_h[32];
  logic [DW-1:0] dat_h[32];

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_list.size()) begin
        wr_en   = 1'b1;
        wr_data = wr_list[i];
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      rd_h[i]  = fifo_read;
      vld_h[i] = m_valid;
      dat_h[i] = m_data;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    wr_list.delete();
  endtask

  initial begin
    int nreads;
    rst = 1'b1; enable = 1'b0; flush_req = 1'b0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = '0;

    // 1. reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_read", 32'(fifo_read), 32'd0);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_words", 32'(words_out), 32'd0);
    check_eq("rst_flush", 32'(fifo_flush), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'd0);
    mon_on = 1'b1;
    @(posedge clk); #1;

    // 2. single word latency
    enable = 1'b1; m_ready = 1'b1;
    wr_list = '{8'hAA};
    run(6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t2_rd%0d", i), 32'(rd_h[i]), 32'(i == 1));
      check_eq($sformatf("t2_vld%0d", i), 32'(vld_h[i]), 32'(i == 3));
    end
    check_eq("t2_data", 32'(dat_h[3]), 32'hAA);
    check_eq("t2_words", 32'(words_out), 32'd1);
    check_eq("t2_cnt", 32'(fifo_cnt), 32'd0);

    // 3. backpressure
    m_ready = 1'b0;
    wr_list = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    run(10);
    nreads = 0;
    for (int i = 0; i < 10; i++) nreads += int'(rd_h[i]);
    check_eq("t3_reads", 32'(nreads), 32'd2);
    check_eq("t3_occ", 32'(occupancy), 32'd2);
    check_eq("t3_cnt", 32'(fifo_cnt), 32'd2);
    check_eq("t3_head", 32'(m_data), 32'hC0);
    m_ready = 1'b1;
    run(6);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t3_vld%0d", i), 32'(vld_h[i]), 32'd1);
      check_eq($sformatf("t3_dat%0d", i), 32'(dat_h[i]), 32'(8'hC0 + i));
    end
    check_eq("t3_vld4", 32'(vld_h[4]), 32'd0);
    check_eq("t3_words", 32'(words_out), 32'd5);

    // 4. full throughput
    enable = 1'b0;
    wr_list = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    run(5);
    check_eq("t4_prefill", 32'(fifo_cnt), 32'd4);
    enable = 1'b1;
    run(8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t4_rd%0d", i), 32'(rd_h[i]), 32'(i < 4));
      check_eq($sformatf("t4_vld%0d", i), 32'(vld_h[i]), 32'(i >= 2 && i < 6));
      if (i >= 2 && i < 6) check_eq($sformatf("t4_dat%0d", i), 32'(dat_h[i]), 32'(8'hD0 + i - 2));
    end
    check_eq("t4_words", 32'(words_out), 32'd9);

    // 5. flush with a full skid
    enable = 1'b0; m_ready = 1'b0;
    wr_list = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
    run(5);
    enable = 1'b1;
    for (int i = 0; i < 20 && occupancy != 2'd2; i++) begin
      @(posedge clk); #1;
    end
    check_eq("t5_fill", 32'(occupancy), 32'd2);
    flush_req = 1'b1;
    @(negedge clk);
    check_eq("t5_flush", 32'(fifo_flush), 32'd1);
    check_eq("t5_noread", 32'(fifo_read), 32'd0);
    @(posedge clk); #1;
    flush_req = 1'b0;
    check_eq("t5_valid", 32'(m_valid), 32'd0);
    check_eq("t5_occ", 32'(occupancy), 32'd0);
    check_eq("t5_cnt", 32'(fifo_cnt), 32'd0);
    check_eq("t5_words", 32'(words_out), 32'd9);

    // 6. enable dropped with a word in flight, then reset with a full skid
    enable = 1'b0; m_ready = 1'b1;
    wr_list = '{8'hF0, 8'hF1};
    run(3);
    enable = 1'b1;
    @(negedge clk);
    check_eq("t6_read", 32'(fifo_read), 32'd1);
    @(posedge clk); #1;
    enable = 1'b0;
    run(5);
    nreads = 0;
    for (int i = 0; i < 5; i++) nreads += int'(rd_h[i]);
    check_eq("t6_noreads", 32'(nreads), 32'd0);
    check_eq("t6_vld", 32'(vld_h[1]), 32'd1);
    check_eq("t6_dat", 32'(dat_h[1]), 32'hF0);
    check_eq("t6_cnt", 32'(fifo_cnt), 32'd1);
    m_ready = 1'b0; enable = 1'b1;
    wr_list = '{8'h60, 8'h61};
    run(6);
    check_eq("t6_occ2", 32'(occupancy), 32'd2);
    check_eq("t6_cnt2", 32'(fifo_cnt), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b0;
    check_eq("t6_rvalid", 32'(m_valid), 32'd0);
    check_eq("t6_rocc", 32'(occupancy), 32'd0);
    check_eq("t6_rwords", 32'(words_out), 32'd0);
    check_eq("t6_rread", 32'(fifo_read), 32'd0);
    check_eq("t6_rflush", 32'(fifo_flush), 32'd0);
    check_eq("t6_rdata", 32'(m_data), 32'd0);
    check_eq("t6_rcnt", 32'(fifo_cnt), 32'd1);

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 3000; c++) begin
      wr_en     = ($urandom_range(0, 99) < 60);
      wr_data   = DW'($urandom);
      enable    = ($urandom_range(0, 99) < 85);
      m_ready   = ($urandom_range(0, 99) < 65);
      flush_req = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    wr_en = 1'b0; flush_req = 1'b0; rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("drain_owed", 32'(exp_q.size()), 32'd0);
    check_eq("drain_fifo", 32'(fifo_cnt), 32'd0);
    mon_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side companion to the team's synchronous `fifo`; the engine that drains it.
- Issues `read` strobes into the FIFO's read port and absorbs its 1-cycle read latency.
- Presents the words as a valid/ready stream through a 2-entry skid buffer, so a consumer (UART TX, SPI master, etc.) gets full throughput under backpressure.
- Also owns FIFO flush sequencing for the read side.

Parameters:
DATA_WIDTH, 8, width of FIFO words and m_data
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  permits new FIFO reads; 0 = stop issuing reads (in-flight and buffered words still deliver)
flush_req  in  1  one-cycle pulse: discard everything buffered and flush the FIFO
fifo_empty  in  1  FIFO empty flag
fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after a read is sampled, held until next read
fifo_read  out  1  FIFO read strobe (combinational from registered state + inputs)
fifo_flush  out  1  FIFO flush strobe
m_valid  out  1  stream word valid
m_ready  in  1  consumer accepts m_data when m_valid && m_ready
m_data  out  DATA_WIDTH  stream word (registered, skid head)
occupancy  out  2  words held in skid buffer, 0..2
words_out  out  CNT_WIDTH  count of accepted stream beats

Behaviour:
- Clock and reset:
  - Single clock `clk`; reset `rst` is synchronous and active-high.
  - Reset values: m_valid=0, m_data=0, occupancy=0, words_out=0, in-flight flag=0, fifo_read=0, fifo_flush=0.
  - Reset mid-operation drops buffered and in-flight words. The FIFO itself is not flushed by rst.
- FIFO contract:
  - A read sampled at edge N updates empty/count at edge N.
  - fifo_data is valid during the cycle after edge N.
- In-flight flag:
  - `inflight` is set for exactly one cycle after each fifo_read.
  - When inflight=1, fifo_data is captured into the skid buffer at the end of that cycle.
- Read issue rule: fifo_read = enable && !fifo_empty && !flush_req && (occupancy + inflight - pop < 2), where pop = m_valid && m_ready.
  - The rule guarantees the skid never overflows.
  - Steady-state full rate: one read per cycle with m_ready=1.
- Latency: fifo_read at cycle t -> word on m_data/m_valid from cycle t+2.
- Skid buffer:
  - 2 entries, FIFO order. Head drives m_data. m_valid = (occupancy != 0).
  - Simultaneous capture and pop: occupancy is unchanged and order is preserved.
  - Capture into empty skid goes straight to head.
  - m_data holds its value while m_valid && !m_ready (AXI-style stability); it never changes under a stalled beat.
- Flush (flush_req=1 in cycle t):
  - fifo_flush=1 in cycle t and fifo_read=0 in cycle t.
  - Skid cleared at edge t; any capture due in cycle t is discarded; inflight cleared.
  - m_valid=0 from cycle t+1.
  - A pop in cycle t still counts (beat completed before flush).
- words_out: increments on each pop and wraps modulo 2^CNT_WIDTH.
- enable=0: no new reads; the pending in-flight word is still captured; the skid drains normally.
- fifo_empty=1 with inflight=1 is legal (last word); no read issued.

Decomposition:
- Shared header `fifo_defs.vh`: FIFO read latency constant (FIFO_RD_LAT=1) and default DATA_WIDTH, shared with `fifo`.
- One natural sub-module: `skid_buf2`, a 2-entry valid/ready register buffer with push/pop/clear and occupancy. The top holds only read issue, inflight, flush, and counter logic.

Test Plan:
- Bench instantiates `fifo` FIFO_DEPTH=4, DATA_WIDTH=8 feeding the DUT.
1. Reset held 3 cycles, then released -> m_valid=0, fifo_read=0, occupancy=0, words_out=0, fifo_flush=0.
2. Write AA, m_ready=1, enable=1 -> single fifo_read pulse; m_valid=1 with m_data=AA exactly 2 cycles later for 1 cycle; words_out=1; FIFO_CNT=0.
3. Backpressure: write C0..C3, m_ready=0 -> exactly 2 reads issued, occupancy=2, FIFO_CNT=2, m_data=C0 stable. Then m_ready=1 -> C0,C1,C2,C3 on 4 consecutive cycles, words_out=5.
4. Throughput: pre-fill D0..D3, enable=1, m_ready=1 -> fifo_read high 4 consecutive cycles; m_valid high 4 consecutive cycles with D0..D3; no bubbles.
5. Flush: pre-fill E0..E3, m_ready=0 until occupancy=2, pulse flush_req -> fifo_flush=1 and fifo_read=0 that cycle; next cycle m_valid=0, occupancy=0, FIFO empty; words_out unchanged.
6. Control and reset: with inflight=1 drop enable -> word still delivered, no further reads. Assert rst with occupancy=2 -> next cycle all outputs at reset values; FIFO_CNT unchanged.
